// File: rtl/dmem_arbiter.sv
// Two-requester data-memory arbiter: round-robin grant in IDLE, single
// outstanding read with registered per-requester read-data return.
module dmem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic {
    S_IDLE,
    S_READ_WAIT
  } state_t;

  state_t            state_q, state_d;
  logic              last_grant_q, last_grant_d;
  logic              owner_q, owner_d;
  logic              rvalid0_q, rvalid0_d;
  logic              rvalid1_q, rvalid1_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d;
  logic [DATA_W-1:0] rdata1_q, rdata1_d;

  logic              gnt0, gnt1;

  // Tie goes to whichever requester was not granted last.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!reset && state_q == S_IDLE) begin
      if (m0_req && m1_req) begin
        gnt0 = last_grant_q;
        gnt1 = !last_grant_q;
      end else begin
        gnt0 = m0_req;
        gnt1 = m1_req;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    rvalid0_d    = 1'b0;
    rvalid1_d    = 1'b0;
    rdata0_d     = rdata0_q;
    rdata1_d     = rdata1_q;
    mem_en       = 1'b0;
    mem_we       = 1'b0;
    mem_addr     = '0;
    mem_wdata    = '0;

    case (state_q)
      S_IDLE: begin
        if (gnt0) begin
          mem_en       = 1'b1;
          mem_we       = m0_we;
          mem_addr     = m0_addr;
          mem_wdata    = m0_wdata;
          last_grant_d = 1'b0;
          if (!m0_we) begin
            owner_d = 1'b0;
            state_d = S_READ_WAIT;
          end
        end else if (gnt1) begin
          mem_en       = 1'b1;
          mem_we       = m1_we;
          mem_addr     = m1_addr;
          mem_wdata    = m1_wdata;
          last_grant_d = 1'b1;
          if (!m1_we) begin
            owner_d = 1'b1;
            state_d = S_READ_WAIT;
          end
        end
      end
      S_READ_WAIT: begin
        if (owner_q) begin
          rdata1_d  = mem_rdata;
          rvalid1_d = 1'b1;
        end else begin
          rdata0_d  = mem_rdata;
          rvalid0_d = 1'b1;
        end
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
      rvalid0_q    <= 1'b0;
      rvalid1_q    <= 1'b0;
      rdata0_q     <= '0;
      rdata1_q     <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      rvalid0_q    <= rvalid0_d;
      rvalid1_q    <= rvalid1_d;
      rdata0_q     <= rdata0_d;
      rdata1_q     <= rdata1_d;
    end
  end

  assign m0_gnt    = gnt0;
  assign m1_gnt    = gnt1;
  assign m0_rvalid = rvalid0_q;
  assign m1_rvalid = rvalid1_q;
  assign m0_rdata  = rdata0_q;
  assign m1_rdata  = rdata1_q;

endmodule
